rf_wb_scheduler: RTL
====================

Name: rf_wb_scheduler

Overview:
- Owns the single write port of the integer register file (x1..x31, x0 hardwired zero).
- Arbitrates that port round-robin among N_REQ write-back sources, e.g. ALU, LSU and MUL/DIV.
- Keeps a per-register pending scoreboard: issue stalls on WAW hazards, and decode reads RAW busy flags.
- Sits between the execution units and the register file; drives the file's is_write/wb_addr/wb_data directly.

Parameters:
- N_REQ, 3, number of write-back requesters (2..8); index 0 starts with highest priority after reset.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester write request.
- req_addr  input  5*N_REQ  destination register, requester i at bits [5i+4:5i].
- req_data  input  XLEN*N_REQ  write data, requester i at bits [XLEN*i+XLEN-1:XLEN*i].
- req_ready  output  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- is_write  output  1  register-file write enable, registered.
- wb_addr  output  5  register-file write address, registered.
- wb_data  output  XLEN  register-file write data, registered.
- issue_valid  input  1  decode issuing an instruction that writes issue_rd.
- issue_rd  input  5  destination of the issuing instruction.
- issue_ready  output  1  issue accepted this cycle.
- rs1_addr  input  5  decode source-operand query.
- rs2_addr  input  5  decode source-operand query.
- rs1_busy  output  1  rs1 has a write outstanding.
- rs2_busy  output  1  rs2 has a write outstanding.

Behaviour:
- Reset (synchronous, active-high):
  - rr_ptr = 0; pending[31:1] = 0.
  - is_write = 0, wb_addr = 0, wb_data = 0.
  - req_ready = 0 and issue_ready = 0 while reset is high.
  - Reset mid-operation discards any in-flight output write: is_write is 0 in the cycle after reset is sampled.
- Arbitration (combinational, within the cycle):
  - Search req_valid starting at index rr_ptr, wrapping modulo N_REQ; the first valid index g is granted.
  - req_ready = one-hot(g) when any req_valid is high, else 0.
  - req_ready never asserts for a non-valid requester.
  - The port always has capacity (the register file never stalls), so the grant always completes the handshake.
- Pointer update: on a handshake with index g, rr_ptr <= (g+1) mod N_REQ. With no handshake, rr_ptr holds.
- Output stage (1-cycle latency):
  - On a handshake, next cycle: is_write = (req_addr[g] != 0), wb_addr = req_addr[g], wb_data = req_data[g].
  - With no handshake, next cycle is_write = 0; wb_addr and wb_data hold their last values.
  - At most one write per cycle.
- Writes to x0: handshake completes, round-robin advances, is_write stays 0, scoreboard unaffected.
- Scoreboard:
  - pending[r] is set when issue_valid & issue_ready & issue_rd == r & r != 0.
  - pending[r] is cleared on a handshake whose req_addr == r, in the same edge the output stage registers the write.
  - A clear of a register that is not pending has no effect.
  - The cleared register is not busy in the cycle is_write is high for it. Decode bypasses via the register file's next-cycle read; no data forwarding here.
- issue_ready (combinational) = !reset & (issue_rd == 0 | !pending[issue_rd] | clear_hit).
  - clear_hit means a handshake this cycle targets issue_rd.
  - If clear and set of the same register coincide, set wins and pending stays 1.
  - issue_valid with issue_rd == 0 is always accepted and sets nothing.
- rs1_busy / rs2_busy:
  - rsX_busy = (rsX_addr != 0) & pending[rsX_addr] & !clear_hit_rsX.
  - clear_hit_rsX means a handshake this cycle targets rsX_addr.
- Simultaneous events:
  - All N_REQ valid: exactly one granted; the others hold valid, addr and data stable until granted (requester obligation).
  - Starvation bound: any continuously valid requester is granted within N_REQ cycles.

Test Plan:
- Reset, then requester 1 writes x5=0xDEADBEEF -> req_ready=3'b010 same cycle; next cycle is_write=1, wb_addr=5, wb_data=0xDEADBEEF; cycle after, is_write=0.
- All three requesters valid for 6 cycles (x1,x2,x3) -> grants 0,1,2,0,1,2; is_write high on 6 consecutive cycles with matching addr/data.
- Issue rd=7 -> pending; rs1_addr=7 gives rs1_busy=1; second issue rd=7 gives issue_ready=0; requester 0 writes x7 -> that cycle issue_ready=1 and rs1_busy=0; next cycle pending[7] stays set (set wins).
- Requester 2 writes x0=0x1234 -> handshake completes, is_write=0 next cycle, rr_ptr=0.
- Issue rd=0 -> issue_ready=1; rs1_addr=0 -> rs1_busy=0 always.
- Reset asserted the cycle a handshake occurs, with pending[3]=1 -> next cycle is_write=0, pending cleared, rs1_addr=3 gives rs1_busy=0, first grant after reset goes to requester 0.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: round-robin owner of the integer register file write port,
// with a per-register pending scoreboard for WAW issue stalls and RAW busy flags.
module rf_wb_scheduler #(
   parameter int N_REQ = 3,
   parameter int XLEN  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [5*N_REQ-1:0]    req_addr,
   input  logic [XLEN*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  is_write,
   output logic [4:0]            wb_addr,
   output logic [XLEN-1:0]       wb_data,
   input  logic                  issue_valid,
   input  logic [4:0]            issue_rd,
   output logic                  issue_ready,
   input  logic [4:0]            rs1_addr,
   input  logic [4:0]            rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gnt_idx;
   logic [PW-1:0]   ptr_next;
   logic            found;
   logic            fire;
   logic [4:0]      sel_addr;
   logic [XLEN-1:0] sel_data;
   logic [31:0]     pending;
   logic [31:0]     pending_next;
   logic [31:0]     clr_vec;
   logic [31:0]     set_vec;
   logic            hit_rd;
   logic            hit_rs1;
   logic            hit_rs2;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin : arb
      int j;
      j         = 0;
      found     = 1'b0;
      gnt_idx   = '0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(rr_ptr) + k) % N_REQ;
         if (!found && req_valid[j]) begin
            found    = 1'b1;
            gnt_idx  = PW'(j);
            sel_addr = req_addr[5*j +: 5];
            sel_data = req_data[XLEN*j +: XLEN];
         end
      end
   end

   always_comb begin
      fire      = found & !reset;
      req_ready = '0;
      if (fire) req_ready[gnt_idx] = 1'b1;
      ptr_next  = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end

   always_comb begin
      hit_rd      = fire & (sel_addr == issue_rd);
      hit_rs1     = fire & (sel_addr == rs1_addr);
      hit_rs2     = fire & (sel_addr == rs2_addr);
      issue_ready = !reset & ((issue_rd == 5'd0) | !pending[issue_rd] | hit_rd);
      rs1_busy    = (rs1_addr != 5'd0) & pending[rs1_addr] & !hit_rs1;
      rs2_busy    = (rs2_addr != 5'd0) & pending[rs2_addr] & !hit_rs2;
      clr_vec     = fire ? (32'd1 << sel_addr) : '0;
      set_vec     = (issue_valid & issue_ready) ? (32'd1 << issue_rd) : '0;
      // Set is applied after clear so a coinciding issue keeps the register busy.
      pending_next = ((pending & ~clr_vec) | set_vec) & ~32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr   <= '0;
         pending  <= '0;
         is_write <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         pending  <= pending_next;
         is_write <= fire & (sel_addr != 5'd0);
         if (fire) begin
            rr_ptr  <= ptr_next;
            wb_addr <= sel_addr;
            wb_data <= sel_data;
         end
      end
   end

endmodule
